// File: rtl/c4_game_driver.sv
// c4_game_driver: player-side controller for the connect4 move engine.
//
// Buffers host column moves in a FIFO, issues them one at a time on the
// engine op channel with alternating player ids, consumes the engine result
// channel, classifies each result and keeps saturating game statistics.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   mv_valid, mv_ready, mv_col    host move push channel (mv_ready = FIFO not full)
//   op_valid, op_ready            move request handshake toward the engine
//   op_player_id, op_col_id       player and column of the outstanding request
//   re_valid, re_ready            engine result handshake
//   re_err, re_is_finished,
//   re_winner, re_tie             result fields
//   clr_stats                     synchronous clear of all statistics counters
//   cur_player                    player that will issue the next move
//   fifo_level                    number of buffered moves
//   busy                          a transaction is in flight
//   evt_valid, evt_code           one pulse per consumed result: 0 move, 1 err, 2 win, 3 tie
//   game_cnt, win0_cnt, win1_cnt,
//   tie_cnt, err_cnt              saturating statistics counters
module c4_game_driver #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mv_valid,
    output logic                          mv_ready,
    input  logic [2:0]                    mv_col,
    input  logic                          op_ready,
    output logic                          op_valid,
    output logic                          op_player_id,
    output logic [2:0]                    op_col_id,
    output logic                          re_ready,
    input  logic                          re_valid,
    input  logic                          re_err,
    input  logic                          re_is_finished,
    input  logic                          re_winner,
    input  logic                          re_tie,
    input  logic                          clr_stats,
    output logic                          cur_player,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          evt_valid,
    output logic [1:0]                    evt_code,
    output logic [CNT_W-1:0]              game_cnt,
    output logic [CNT_W-1:0]              win0_cnt,
    output logic [CNT_W-1:0]              win1_cnt,
    output logic [CNT_W-1:0]              tie_cnt,
    output logic [CNT_W-1:0]              err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [LW-1:0]   r_level;

    logic            w_push;
    logic            w_pop;
    logic            w_re_fire;
    logic [1:0]      w_code;
    logic            w_inc_err;
    logic            w_inc_game;
    logic            w_inc_tie;
    logic            w_inc_w0;
    logic            w_inc_w1;

    assign mv_ready   = r_level != FULL;
    assign fifo_level = r_level;
    assign busy       = r_state != S_IDLE;

    // op_valid is only ever high in ISSUE, so this is exactly the op fire.
    assign w_push    = mv_valid & mv_ready;
    assign w_pop     = op_valid & op_ready;
    assign w_re_fire = re_valid & re_ready;

    // Error outranks finished; tie outranks win.
    always_comb begin
        w_code     = re_err ? 2'd1 : re_is_finished ? (re_tie ? 2'd3 : 2'd2) : 2'd0;
        w_inc_err  = w_re_fire & re_err;
        w_inc_game = w_re_fire & ~re_err & re_is_finished;
        w_inc_tie  = w_inc_game & re_tie;
        w_inc_w0   = w_inc_game & ~re_tie & ~re_winner;
        w_inc_w1   = w_inc_game & ~re_tie & re_winner;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= mv_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            op_valid     <= 1'b0;
            op_player_id <= 1'b0;
            op_col_id    <= 3'd0;
            re_ready     <= 1'b0;
            cur_player   <= 1'b0;
            evt_valid    <= 1'b0;
            evt_code     <= 2'd0;
        end else begin
            evt_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The head entry stays in the FIFO until the engine accepts it.
                    if (r_level != '0) begin
                        r_state      <= S_ISSUE;
                        op_valid     <= 1'b1;
                        op_col_id    <= r_mem[r_rp];
                        op_player_id <= cur_player;
                    end
                end
                S_ISSUE: begin
                    if (w_pop) begin
                        r_state  <= S_WAIT_RE;
                        op_valid <= 1'b0;
                        re_ready <= 1'b1;
                    end
                end
                S_WAIT_RE: begin
                    if (w_re_fire) begin
                        r_state   <= S_IDLE;
                        re_ready  <= 1'b0;
                        evt_valid <= 1'b1;
                        evt_code  <= w_code;
                        // A rejected move is retried by the same player.
                        if (!re_err)
                            cur_player <= re_is_finished ? 1'b0 : ~cur_player;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    // clr_stats takes precedence over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            game_cnt <= '0;
            win0_cnt <= '0;
            win1_cnt <= '0;
            tie_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            game_cnt <= sat_inc(game_cnt, w_inc_game);
            win0_cnt <= sat_inc(win0_cnt, w_inc_w0);
            win1_cnt <= sat_inc(win1_cnt, w_inc_w1);
            tie_cnt  <= sat_inc(tie_cnt, w_inc_tie);
            err_cnt  <= sat_inc(err_cnt, w_inc_err);
        end
    end
endmodule
